rename_map_table: RTL and testbench
===================================

Name: rename_map_table

Overview:
- Parametrised register-rename map table for the OOO-OTTER Tomasulo core.
- Tracks, per architectural register, whether a result is outstanding and which reservation-station tag will produce it.
- Provides source-operand tags to issue, and snoops NUM_CDB CDB channels to release registers and drive register-file write ports.
- Generalises the single-CDB table:
  - multiple CDB channels and source ports;
  - newest-writer rename over a busy register;
  - stale-result suppression;
  - x0 protection;
  - pipeline flush.

Parameters:
NUM_REGS, 32, architectural registers; address width AW = $clog2(NUM_REGS)
TAG_W, 3, reservation-station tag width; tag value 0 is INVALID (no producer)
XLEN, 32, data width
NUM_SRC, 3, source lookup ports (rs1, rs2, store-data)
NUM_CDB, 2, CDB broadcast channels, and register-file write ports

Ports:
CLK  in  1  clock, all state updates on posedge
RST  in  1  reset, asynchronous, active-high; clears entire table
issue_valid  in  1  an instruction issues this cycle
issue_rd_we  in  1  issued instruction writes rd
issue_rd_addr  in  AW  destination register
issue_tag  in  TAG_W  RS tag allocated to issued instruction
src_used  in  NUM_SRC  per source: operand is a register
src_addr  in  NUM_SRC*AW  per source register address
src_tag  out  NUM_SRC*TAG_W  producer tag, 0 if value is in register file
src_ready  out  NUM_SRC  1 = read value from register file
cdb_valid  in  NUM_CDB  channel broadcasts this cycle
cdb_tag  in  NUM_CDB*TAG_W  broadcast tags
cdb_data  in  NUM_CDB*XLEN  broadcast values
rf_we  out  NUM_CDB  register-file write enable per channel
rf_addr  out  NUM_CDB*AW  register-file write address per channel
rf_data  out  NUM_CDB*XLEN  register-file write data per channel
flush  in  1  discard all outstanding mappings (mispredict)
busy_vec  out  NUM_REGS  per-register busy flag (registered state)

Behaviour:
- State:
  - one entry per register: {busy, tag};
  - reset: all busy=0, tag=0.
  - After reset, outputs are: busy_vec=0, rf_we=0, src_ready=all 1, src_tag=0.
- Lookup (combinational, from current state):
  - if src_used[k] and entry busy: src_ready[k]=0, src_tag[k]=entry.tag;
  - otherwise: src_ready[k]=1, src_tag[k]=0.
  - Address 0 always reads ready.
  - A lookup in the same cycle as an issue to the same register sees the old mapping. The instruction's own rd does not affect its sources.
- Release (combinational detect, state updated on posedge):
  - for channel c with cdb_valid[c], find register r with busy and tag==cdb_tag[c];
  - then rf_we[c]=1, rf_addr[c]=r, rf_data[c]=cdb_data[c];
  - entry r is cleared at the next posedge.
  - The RF commits on the same edge, so release has zero-cycle latency and there is no stale-read window.
  - If no entry matches (register already renamed to a newer tag): rf_we[c]=0. The stale result is never written.
  - Tags are unique, so at most one register matches per channel.
  - Two channels carrying the same valid tag is illegal; the lower channel index wins.
- Rename (posedge):
  - issue_valid & issue_rd_we & issue_rd_addr!=0 & issue_tag!=0 → entry ← {busy=1, tag=issue_tag}.
  - Rename overwrites a busy entry: newest writer wins.
  - issue_tag==0, or rd=0, leaves the entry unchanged.
- Simultaneous rename and release of the same register:
  - rename wins, entry holds the new tag;
  - rf_we for the old tag is suppressed, because the value is architecturally dead.
- Rename to one register and release of another in the same cycle: both take effect.
- flush (posedge): all entries cleared; overrides rename and release in that cycle; rf_we forced 0 while flush=1.
- RST asserted mid-operation: table cleared immediately, independent of CLK; rf_we drops combinationally.

Optional Feature:
MT_CDB_BYPASS_EN:
- Defined:
  - lookup also compares the busy entry's tag against valid CDB tags in the same cycle;
  - on a match: src_ready=1, src_tag=0, and extra output src_fwd_data (NUM_SRC*XLEN) carries the matching cdb_data;
  - the issuing RS takes the value directly.
- Undefined:
  - no src_fwd_data port;
  - lookup returns the producer tag, and the RS captures the value by snooping the CDB in its issue cycle.

Test Plan:
- Reset then lookup x5 with src_used=1 → src_ready=1, src_tag=0, busy_vec=0.
- Issue rd=5 tag=3; next cycle look up x5 → ready=0, tag=3. Then CDB0 tag=3 data=0xDEADBEEF → same cycle rf_we[0]=1, addr=5, data=0xDEADBEEF; next cycle busy_vec[5]=0.
- Rename x7 to tag 2, then to tag 4; broadcast tag 2 → rf_we=0, x7 still tag 4. Broadcast tag 4 → rf_we=1, addr=7.
- Same cycle: issue rd=9 tag=5 while CDB1 broadcasts x9's old tag 1 → rf_we[1]=0; x9 busy with tag 5.
- CDB0 tag=1 (x3) and CDB1 tag=6 (x12) in the same cycle → both ports write, both entries cleared. Issue rd=0 tag=2 → busy_vec[0] stays 0.
- Three busy registers, assert flush → busy_vec=0 next cycle, rf_we=0 during flush. Assert RST asynchronously mid-cycle → table clears without a clock edge.

Source files
------------

// File: rtl/rename_map_table_if.sv
`default_nettype none
// ============================================================================
// Module      : rename_map_table_if
// Description : Bundle of issue, source-lookup, CDB-snoop, register-file write
//               and flush signals for the register-rename map table.
//               The src_fwd_data signal exists only when MT_CDB_BYPASS_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rename_map_table_if #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 3,
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 3,
    parameter int NUM_CDB  = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     issue_valid;
    logic                     issue_rd_we;
    logic [AW-1:0]            issue_rd_addr;
    logic [TAG_W-1:0]         issue_tag;
    logic [NUM_SRC-1:0]       src_used;
    logic [NUM_SRC*AW-1:0]    src_addr;
    logic [NUM_SRC*TAG_W-1:0] src_tag;
    logic [NUM_SRC-1:0]       src_ready;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;
    logic [NUM_CDB-1:0]       rf_we;
    logic [NUM_CDB*AW-1:0]    rf_addr;
    logic [NUM_CDB*XLEN-1:0]  rf_data;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy_vec;
`ifdef MT_CDB_BYPASS_EN
    logic [NUM_SRC*XLEN-1:0]  src_fwd_data;
`endif

    // Issue/dispatch side: drives requests, observes the table.
    modport master (
        output issue_valid, issue_rd_we, issue_rd_addr, issue_tag,
        output src_used, src_addr, cdb_valid, cdb_tag, cdb_data, flush,
        input  src_tag, src_ready, rf_we, rf_addr, rf_data, busy_vec
`ifdef MT_CDB_BYPASS_EN
        , input src_fwd_data
`endif
    );

    // Map-table side.
    modport slave (
        input  issue_valid, issue_rd_we, issue_rd_addr, issue_tag,
        input  src_used, src_addr, cdb_valid, cdb_tag, cdb_data, flush,
        output src_tag, src_ready, rf_we, rf_addr, rf_data, busy_vec
`ifdef MT_CDB_BYPASS_EN
        , output src_fwd_data
`endif
    );
endinterface
`default_nettype wire

// File: rtl/rename_map_table.sv
`default_nettype none
// ============================================================================
// Module      : rename_map_table
// Description : Register-rename map table. One {busy, tag} entry per
//               architectural register; provides producer tags to issue,
//               snoops NUM_CDB result buses to release registers and drive the
//               register-file write ports. Newest writer wins, stale results
//               are dropped, x0 is never renamed, flush clears everything.
//               Optional macro MT_CDB_BYPASS_EN: same-cycle CDB bypass on
//               lookup with an extra src_fwd_data output.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_map_table #(
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 3,
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 3,
    parameter int NUM_CDB  = 2
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    rename_map_table_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0]      r_busy;
    logic [TAG_W-1:0]         r_tag [NUM_REGS];

    logic                     w_ren;
    logic [NUM_CDB-1:0]       w_rf_we;
    logic [AW-1:0]            w_rf_addr [NUM_CDB];
    logic [NUM_REGS-1:0]      w_rel;
    logic [NUM_SRC-1:0]       w_lk_busy;
    logic [TAG_W-1:0]         w_lk_tag [NUM_SRC];
    logic [NUM_SRC-1:0]       w_src_ready;
    logic [NUM_SRC*TAG_W-1:0] w_src_tag;
`ifdef MT_CDB_BYPASS_EN
    logic [NUM_SRC*XLEN-1:0]  w_src_fwd;
`endif

    // A rename only happens for a real destination with a real tag.
    assign w_ren = bus.issue_valid && bus.issue_rd_we &&
                   (bus.issue_rd_addr != '0) && (bus.issue_tag != '0);

    // Per-channel release detect: find the register still waiting on this tag,
    // then drop duplicates, results killed by a same-cycle rename, and flush.
    always_comb begin
        w_rf_we = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            w_rf_addr[c] = '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.cdb_valid[c] && r_busy[r] &&
                    (r_tag[r] == bus.cdb_tag[c*TAG_W +: TAG_W])) begin
                    w_rf_we[c]   = 1'b1;
                    w_rf_addr[c] = AW'(r);
                end
            end
            for (int j = 0; j < NUM_CDB; j++) begin
                if ((j < c) && bus.cdb_valid[j] &&
                    (bus.cdb_tag[j*TAG_W +: TAG_W] == bus.cdb_tag[c*TAG_W +: TAG_W]))
                    w_rf_we[c] = 1'b0;
            end
            if (w_ren && (bus.issue_rd_addr == w_rf_addr[c]))
                w_rf_we[c] = 1'b0;
            if (bus.flush || RST)
                w_rf_we[c] = 1'b0;
        end
    end

    // Collapse the per-channel releases into a per-register clear mask.
    always_comb begin
        w_rel = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_rf_we[c] && (w_rf_addr[c] == AW'(r)))
                    w_rel[r] = 1'b1;
            end
        end
    end

    // Table update: flush beats rename, rename beats release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy <= '0;
            for (int r = 0; r < NUM_REGS; r++)
                r_tag[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (bus.flush) begin
                    r_busy[r] <= 1'b0;
                    r_tag[r]  <= '0;
                end else if (w_ren && (bus.issue_rd_addr == AW'(r))) begin
                    r_busy[r] <= 1'b1;
                    r_tag[r]  <= bus.issue_tag;
                end else if (w_rel[r]) begin
                    r_busy[r] <= 1'b0;
                    r_tag[r]  <= '0;
                end
            end
        end
    end

    // Source lookup against current state; x0 is never busy so it reads ready.
    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            w_lk_busy[k] = 1'b0;
            w_lk_tag[k]  = '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.src_used[k] && r_busy[r] &&
                    (bus.src_addr[k*AW +: AW] == AW'(r))) begin
                    w_lk_busy[k] = 1'b1;
                    w_lk_tag[k]  = r_tag[r];
                end
            end
        end
    end

    // Lookup result, optionally short-circuited by a same-cycle CDB match.
    always_comb begin
        w_src_ready = '1;
        w_src_tag   = '0;
`ifdef MT_CDB_BYPASS_EN
        w_src_fwd   = '0;
`endif
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_lk_busy[k]) begin
                w_src_ready[k]              = 1'b0;
                w_src_tag[k*TAG_W +: TAG_W] = w_lk_tag[k];
            end
`ifdef MT_CDB_BYPASS_EN
            // Walk channels high to low so the lowest matching channel wins.
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (w_lk_busy[k] && bus.cdb_valid[c] &&
                    (bus.cdb_tag[c*TAG_W +: TAG_W] == w_lk_tag[k])) begin
                    w_src_ready[k]              = 1'b1;
                    w_src_tag[k*TAG_W +: TAG_W] = '0;
                    w_src_fwd[k*XLEN +: XLEN]   = bus.cdb_data[c*XLEN +: XLEN];
                end
            end
`endif
        end
    end

    assign bus.src_ready = w_src_ready;
    assign bus.src_tag   = w_src_tag;
    assign bus.rf_we     = w_rf_we;
    assign bus.rf_data   = bus.cdb_data;
    assign bus.busy_vec  = r_busy;
`ifdef MT_CDB_BYPASS_EN
    assign bus.src_fwd_data = w_src_fwd;
`endif

    generate
        for (genvar c = 0; c < NUM_CDB; c++) begin : g_rf_addr
            assign bus.rf_addr[c*AW +: AW] = w_rf_addr[c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rename_map_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_map_table
// Description : Directed scenarios plus randomized traffic for the rename map
//               table, checked every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_map_table;
    localparam int NUM_REGS = 32;
    localparam int TAG_W    = 3;
    localparam int XLEN     = 32;
    localparam int NUM_SRC  = 3;
    localparam int NUM_CDB  = 2;
    localparam int AW       = $clog2(NUM_REGS);
    localparam int NTAGS    = 1 << TAG_W;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    rename_map_table_if #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .XLEN(XLEN),
                          .NUM_SRC(NUM_SRC), .NUM_CDB(NUM_CDB)) mif ();

    rename_map_table #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .XLEN(XLEN),
                       .NUM_SRC(NUM_SRC), .NUM_CDB(NUM_CDB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (mif)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: which registers await a result, and from which tag.
    bit m_busy   [NUM_REGS];
    int m_tag    [NUM_REGS];
    bit inflight [NTAGS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cdbtag(input int c);
        return int'(mif.cdb_tag[c*TAG_W +: TAG_W]);
    endfunction

    function automatic bit renaming(input int r);
        return mif.issue_valid && mif.issue_rd_we && (mif.issue_rd_addr != '0) &&
               (mif.issue_tag != '0) && (int'(mif.issue_rd_addr) == r);
    endfunction

    // Which register (if any) the channel's result is written to.
    function automatic bit exp_we(input int c, output int reg_idx);
        int t;
        reg_idx = -1;
        if (!mif.cdb_valid[c] || mif.flush || RST) return 1'b0;
        t = cdbtag(c);
        for (int r = 0; r < NUM_REGS; r++)
            if (m_busy[r] && m_tag[r] == t) reg_idx = r;
        if (reg_idx < 0) return 1'b0;
        for (int j = 0; j < c; j++)
            if (mif.cdb_valid[j] && cdbtag(j) == t) return 1'b0;
        if (renaming(reg_idx)) return 1'b0;
        return 1'b1;
    endfunction

    // Model state update.
    always @(posedge CLK or posedge RST) begin
        bit rel [NUM_CDB];
        int rr  [NUM_CDB];
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
            for (int t = 0; t < NTAGS; t++) inflight[t] = 0;
        end else begin
            for (int c = 0; c < NUM_CDB; c++) rel[c] = exp_we(c, rr[c]);
            if (mif.flush) begin
                for (int r = 0; r < NUM_REGS; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
                for (int t = 0; t < NTAGS; t++) inflight[t] = 0;
            end else begin
                for (int c = 0; c < NUM_CDB; c++)
                    if (rel[c]) begin m_busy[rr[c]] = 0; m_tag[rr[c]] = 0; end
                for (int c = 0; c < NUM_CDB; c++)
                    if (mif.cdb_valid[c]) inflight[cdbtag(c)] = 0;
                if (renaming(int'(mif.issue_rd_addr))) begin
                    m_busy[int'(mif.issue_rd_addr)] = 1;
                    m_tag[int'(mif.issue_rd_addr)]  = int'(mif.issue_tag);
                end
                if (mif.issue_valid && mif.issue_tag != '0) inflight[int'(mif.issue_tag)] = 1;
            end
        end
    end

    // Compare process: every cycle, all outputs against the model.
    always @(negedge CLK) begin
        int a, et, er, rix;
        bit ew;
        logic [NUM_REGS-1:0] eb;
        for (int k = 0; k < NUM_SRC; k++) begin
            a  = int'(mif.src_addr[k*AW +: AW]);
            er = 1; et = 0;
            if (mif.src_used[k] && a != 0 && m_busy[a]) begin
                er = 0; et = m_tag[a];
`ifdef MT_CDB_BYPASS_EN
                for (int c = 0; c < NUM_CDB; c++) begin
                    if (er == 0 && mif.cdb_valid[c] && cdbtag(c) == et) begin
                        er = 1; et = 0;
                        chk($sformatf("src_fwd_data[%0d]", k), 64'(mif.src_fwd_data[k*XLEN +: XLEN]),
                            64'(mif.cdb_data[c*XLEN +: XLEN]));
                    end
                end
`endif
            end
            chk($sformatf("src_ready[%0d]", k), 64'(mif.src_ready[k]), 64'(er));
            chk($sformatf("src_tag[%0d]", k), 64'(mif.src_tag[k*TAG_W +: TAG_W]), 64'(et));
        end
        for (int c = 0; c < NUM_CDB; c++) begin
            ew = exp_we(c, rix);
            chk($sformatf("rf_we[%0d]", c), 64'(mif.rf_we[c]), 64'(ew));
            if (ew) begin
                chk($sformatf("rf_addr[%0d]", c), 64'(mif.rf_addr[c*AW +: AW]), 64'(rix));
                chk($sformatf("rf_data[%0d]", c), 64'(mif.rf_data[c*XLEN +: XLEN]),
                    64'(mif.cdb_data[c*XLEN +: XLEN]));
            end
        end
        for (int r = 0; r < NUM_REGS; r++) eb[r] = m_busy[r];
        chk("busy_vec", 64'(mif.busy_vec), 64'(eb));
    end

    task automatic idle();
        mif.issue_valid   = 0;
        mif.issue_rd_we   = 0;
        mif.issue_rd_addr = '0;
        mif.issue_tag     = '0;
        mif.src_used      = '0;
        mif.src_addr      = '0;
        mif.cdb_valid     = '0;
        mif.cdb_tag       = '0;
        mif.cdb_data      = '0;
        mif.flush         = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input int rd, input int tag);
        mif.issue_valid   = 1;
        mif.issue_rd_we   = 1;
        mif.issue_rd_addr = AW'(rd);
        mif.issue_tag     = TAG_W'(tag);
    endtask

    task automatic lookup(input int k, input int rd);
        mif.src_used[k]          = 1'b1;
        mif.src_addr[k*AW +: AW] = AW'(rd);
    endtask

    task automatic bcast(input int c, input int tag, input logic [XLEN-1:0] data);
        mif.cdb_valid[c]              = 1'b1;
        mif.cdb_tag[c*TAG_W +: TAG_W] = TAG_W'(tag);
        mif.cdb_data[c*XLEN +: XLEN]  = data;
    endtask

    task automatic rand_cycle();
        int freet[$];
        int busyt[$];
        int idx;
        idle();
        for (int t = 1; t < NTAGS; t++)
            if (inflight[t]) busyt.push_back(t); else freet.push_back(t);
        if ($urandom_range(0, 9) < 6 && freet.size() > 0) begin
            mif.issue_valid   = 1;
            mif.issue_rd_we   = ($urandom_range(0, 4) != 0);
            mif.issue_rd_addr = AW'($urandom_range(0, 15));
            mif.issue_tag     = ($urandom_range(0, 15) == 0) ? '0 :
                                TAG_W'(freet[$urandom_range(0, freet.size() - 1)]);
        end
        for (int c = 0; c < NUM_CDB; c++) begin
            if (busyt.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, busyt.size() - 1);
                bcast(c, busyt[idx], XLEN'($urandom));
                if ($urandom_range(0, 19) != 0) busyt.delete(idx);
            end
        end
        for (int k = 0; k < NUM_SRC; k++)
            if ($urandom_range(0, 3) != 0) lookup(k, $urandom_range(0, 15));
        mif.flush = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        RST = 1;
        repeat (2) @(posedge CLK);
        #1 RST = 0;

        // Reset state lookup.
        lookup(0, 5);
        #1;
        chk("reset src_ready", 64'(mif.src_ready[0]), 64'd1);
        chk("reset src_tag", 64'(mif.src_tag[0 +: TAG_W]), 64'd0);
        chk("reset busy_vec", 64'(mif.busy_vec), 64'd0);
        chk("reset rf_we", 64'(mif.rf_we), 64'd0);

        // Rename x5 to tag 3, look it up, then release it.
        step(); idle(); issue(5, 3);
        step(); idle(); lookup(0, 5);
        #1;
        chk("x5 ready", 64'(mif.src_ready[0]), 64'd0);
        chk("x5 tag", 64'(mif.src_tag[0 +: TAG_W]), 64'd3);
        bcast(0, 3, 32'hDEADBEEF);
        #1;
        chk("x5 rf_we", 64'(mif.rf_we), 64'b01);
        chk("x5 rf_addr", 64'(mif.rf_addr[0 +: AW]), 64'd5);
        chk("x5 rf_data", 64'(mif.rf_data[0 +: XLEN]), 64'hDEADBEEF);
        step(); idle();
        #1;
        chk("x5 released", 64'(mif.busy_vec[5]), 64'd0);

        // Newest writer wins; stale tag is not written back.
        issue(7, 2);
        step(); idle(); issue(7, 4);
        step(); idle(); bcast(0, 2, 32'h1111_2222); lookup(1, 7);
        #1;
        chk("stale rf_we", 64'(mif.rf_we), 64'd0);
        chk("x7 tag", 64'(mif.src_tag[TAG_W +: TAG_W]), 64'd4);
        step(); idle(); bcast(0, 4, 32'h3333_4444);
        #1;
        chk("x7 rf_we", 64'(mif.rf_we), 64'b01);
        chk("x7 rf_addr", 64'(mif.rf_addr[0 +: AW]), 64'd7);

        // Rename and release of the same register in one cycle.
        step(); idle(); issue(9, 1);
        step(); idle(); issue(9, 5); bcast(1, 1, 32'h5555_6666);
        #1;
        chk("x9 rf_we suppressed", 64'(mif.rf_we), 64'd0);
        step(); idle(); lookup(2, 9);
        #1;
        chk("x9 ready", 64'(mif.src_ready[2]), 64'd0);
        chk("x9 tag", 64'(mif.src_tag[2*TAG_W +: TAG_W]), 64'd5);

        // Two channels release two registers; x0 never renames.
        step(); idle(); issue(3, 1);
        step(); idle(); issue(12, 6);
        step(); idle(); bcast(0, 1, 32'hAAAA_0003); bcast(1, 6, 32'hBBBB_000C);
        #1;
        chk("dual rf_we", 64'(mif.rf_we), 64'b11);
        chk("dual rf_addr0", 64'(mif.rf_addr[0 +: AW]), 64'd3);
        chk("dual rf_addr1", 64'(mif.rf_addr[AW +: AW]), 64'd12);
        chk("dual rf_data1", 64'(mif.rf_data[XLEN +: XLEN]), 64'hBBBB_000C);
        step(); idle(); issue(0, 2);
        #1;
        chk("dual cleared", 64'({mif.busy_vec[12], mif.busy_vec[3]}), 64'd0);
        step(); idle();
        #1;
        chk("x0 not busy", 64'(mif.busy_vec[0]), 64'd0);

        // Flush with three busy registers (x9 still busy on tag 5).
        issue(1, 1);
        step(); idle(); issue(2, 2);
        step(); idle();
        #1;
        chk("three busy", 64'(mif.busy_vec), 64'h0000_0206);
        mif.flush = 1; bcast(0, 5, 32'h7777_8888);
        #1;
        chk("flush rf_we", 64'(mif.rf_we), 64'd0);
        step(); idle();
        #1;
        chk("flush busy_vec", 64'(mif.busy_vec), 64'd0);

        // Asynchronous reset between clock edges.
        issue(4, 3);
        step(); idle(); issue(6, 6);
        step(); idle(); bcast(0, 3, 32'h0BAD_F00D);
        #1;
        chk("pre-reset rf_we", 64'(mif.rf_we), 64'b01);
        RST = 1;
        #1;
        chk("async busy_vec", 64'(mif.busy_vec), 64'd0);
        chk("async rf_we", 64'(mif.rf_we), 64'd0);
        step(); idle(); RST = 0;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rand_cycle();
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
